bcd_to_excess3_serial: RTL

//   Bit-serial BCD -> Excess-3 converter (adds 3 to each 4-bit digit), LSB first.

---
 rtl/bcd_to_excess3_serial_pkg.sv | 19 +
 rtl/bcd_to_excess3_serial.sv | 76 +++++++
 2 files changed

// File: rtl/bcd_to_excess3_serial_pkg.sv
// Shared definitions for the serial BCD <-> Excess-3 converter family:
// state encoding, state width and digit size.
package bcd_to_excess3_serial_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned DIGIT_BITS = 4;

  // Bit position within the digit plus the carry of the serial +3 adder.
  typedef enum logic [STATE_W-1:0] {
    S_B0    = 3'd0,
    S_B1_C0 = 3'd1,
    S_B1_C1 = 3'd2,
    S_B2_C0 = 3'd3,
    S_B2_C1 = 3'd4,
    S_B3_C0 = 3'd5,
    S_B3_C1 = 3'd6
  } state_e;

endpackage

// File: rtl/bcd_to_excess3_serial.sv
// Bit-serial BCD -> Excess-3 converter, LSB first. Mealy FSM adding 0011 serially,
// with a digit-boundary strobe (Last) and a registered invalid-digit pulse (Err).
module bcd_to_excess3_serial
  import bcd_to_excess3_serial_pkg::*;
#(
  parameter bit ERR_CHECK = 1'b1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic X,
  input  logic En,
  output logic Z,
  output logic Last,
  output logic Err
);

  state_e state_q, state_d;
  logic   hi_q, hi_d;    // b1|b2 of the digit in flight
  logic   err_q, err_d;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_B0;
      hi_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  // Next state, b1|b2 tracking and the Err pulse.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    err_d   = 1'b0;
    if (state_q == S_B0) hi_d = 1'b0;
    if (En) begin
      case (state_q)
        S_B0:    state_d = X ? S_B1_C1 : S_B1_C0;
        S_B1_C0: begin state_d = X ? S_B2_C1 : S_B2_C0; hi_d = hi_q | X; end
        S_B1_C1: begin state_d = S_B2_C1;               hi_d = hi_q | X; end
        S_B2_C0: begin state_d = S_B3_C0;               hi_d = hi_q | X; end
        S_B2_C1: begin state_d = X ? S_B3_C1 : S_B3_C0; hi_d = hi_q | X; end
        S_B3_C0,
        S_B3_C1: begin
          state_d = S_B0;
          err_d   = ERR_CHECK & X & hi_q;
        end
        default: state_d = S_B0;
      endcase
    end
  end

  // Mealy outputs; forced low during reset and gap cycles.
  always_comb begin
    Z    = 1'b0;
    Last = 1'b0;
    if (En && !Rst) begin
      case (state_q)
        S_B0:    Z = ~X;
        S_B1_C0: Z = ~X;
        S_B1_C1: Z = X;
        S_B2_C0: Z = X;
        S_B2_C1: Z = ~X;
        S_B3_C0: begin Z = X;  Last = 1'b1; end
        S_B3_C1: begin Z = ~X; Last = 1'b1; end
        default: Z = 1'b0;
      endcase
    end
  end

  assign Err = err_q;

endmodule
